// File: rtl/mem_stage.sv
// Memory stage: registers execute results, runs load/store accesses over a req/ack bus,
// and hands completed results to writeback. Stalls upstream while a request waits for ack.
module mem_stage (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  RdE,
  input  logic [2:0]  Funct3E,
  input  logic        ValidE,
  input  logic        RegWriteE,
  input  logic        MemReadE,
  input  logic        MemWriteE,
  input  logic [31:0] DMemRData,
  input  logic        DMemAck,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemBE,
  output logic [31:0] DMemWData,
  output logic        StallM,
  output logic [31:0] ResultW,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic        ValidW,
  output logic        FaultW
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state;
  logic        m_valid;
  logic        m_regwrite;
  logic        m_memread;
  logic        m_memwrite;
  logic [31:0] m_alu;
  logic [31:0] m_wdata;
  logic [4:0]  m_rd;
  logic [2:0]  m_funct3;

  logic        m_store;
  logic        m_load;
  logic        m_memop;
  logic        f3_ok;
  logic        misalign;
  logic        m_fault;
  logic        acc;
  logic        w_fire;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  // A write qualifier takes precedence if execute ever raises both read and write.
  assign m_store = m_memwrite;
  assign m_load  = m_memread & ~m_memwrite;
  assign m_memop = m_valid & (m_memread | m_memwrite);

  always_comb begin
    f3_ok = 1'b0;
    case (m_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~m_store;
      default:                f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    case (m_funct3[1:0])
      2'b01:   misalign = m_alu[0];
      2'b10:   misalign = |m_alu[1:0];
      default: misalign = 1'b0;
    endcase
  end

  assign m_fault = m_memop & (~f3_ok | misalign);
  assign acc     = (state == ACCESS) & ~m_fault;
  assign StallM  = acc & ~DMemAck;
  assign w_fire  = m_valid & ~StallM;

  always_comb begin
    ld_byte = DMemRData[7:0];
    case (m_alu[1:0])
      2'd0: ld_byte = DMemRData[7:0];
      2'd1: ld_byte = DMemRData[15:8];
      2'd2: ld_byte = DMemRData[23:16];
      2'd3: ld_byte = DMemRData[31:24];
      default: ld_byte = DMemRData[7:0];
    endcase
    ld_half = m_alu[1] ? DMemRData[31:16] : DMemRData[15:0];
  end

  always_comb begin
    ld_ext = DMemRData;
    case (m_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = DMemRData;
    endcase
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = m_wdata;
    case (m_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << m_alu[1:0];
        st_data = {4{m_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << m_alu[1:0];
        st_data = {2{m_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = m_wdata;
      end
    endcase
  end

  // Bus outputs come straight from the M registers, so they stay stable until ack.
  assign DMemReq   = acc;
  assign DMemWe    = acc & m_store;
  assign DMemAddr  = acc ? {m_alu[31:2], 2'b00} : 32'd0;
  assign DMemBE    = acc ? st_be : 4'd0;
  assign DMemWData = (acc & m_store) ? st_data : 32'd0;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state      <= IDLE;
      m_valid    <= 1'b0;
      m_regwrite <= 1'b0;
      m_memread  <= 1'b0;
      m_memwrite <= 1'b0;
      m_alu      <= 32'd0;
      m_wdata    <= 32'd0;
      m_rd       <= 5'd0;
      m_funct3   <= 3'd0;
      ResultW    <= 32'd0;
      RdW        <= 5'd0;
      RegWriteW  <= 1'b0;
      ValidW     <= 1'b0;
      FaultW     <= 1'b0;
    end else begin
      if (!StallM) begin
        state      <= (ValidE & (MemReadE | MemWriteE)) ? ACCESS : IDLE;
        m_valid    <= ValidE;
        m_regwrite <= ValidE & RegWriteE;
        m_memread  <= ValidE & MemReadE;
        m_memwrite <= ValidE & MemWriteE;
        m_alu      <= ALUResultE;
        m_wdata    <= WriteDataE;
        m_rd       <= RdE;
        m_funct3   <= Funct3E;
      end
      ValidW    <= w_fire;
      FaultW    <= w_fire & m_fault;
      RegWriteW <= w_fire & ~m_fault & (m_memop ? m_load : m_regwrite);
      if (w_fire) begin
        ResultW <= (m_memop & m_load) ? ld_ext : m_alu;
        RdW     <= m_rd;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the pipelined core, directly downstream of the execute-stage ALU. Registers the ALU result and control from execute, performs load/store accesses on the data-memory bus with a req/ack handshake, and hands completed results to writeback. Stalls upstream while a memory access is outstanding; aligns store data and sign- or zero-extends load data.

## Interface
- No parameters: widths are fixed at 32-bit data and address, 5-bit register index.
- CLK  in  1  clock; all state updates on rising edge.
- nRESET  in  1  synchronous, active-low reset.
- ALUResultE  in  32  ALU result from execute: memory address for loads/stores, writeback value otherwise.
- WriteDataE  in  32  store data (rs2 value).
- RdE  in  5  destination register.
- Funct3E  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ValidE, RegWriteE, MemReadE, MemWriteE  in  1 each  execute-stage qualifiers.
- DMemRData  in  32  read data, valid in the ack cycle.
- DMemAck  in  1  memory completes the current request this cycle.
- DMemReq  out  1  request active; address, controls and data held stable until ack.
- DMemWe  out  1  1 = store, 0 = load.
- DMemAddr  out  32  word address, {addr[31:2], 2'b00}.
- DMemBE  out  4  byte enables.
- DMemWData  out  32  lane-replicated store data.
- StallM  out  1  combinational; holds execute and earlier stages.
- ResultW  out  32  writeback value.
- RdW  out  5  writeback register.
- RegWriteW, ValidW, FaultW  out  1 each  writeback qualifiers; FaultW marks a misaligned access or illegal Funct3E.

## Operation
- M slot: registered copy of the E inputs plus state IDLE / ACCESS. It loads on every edge where StallM=0; if ValidE=0 it loads as an empty slot.
- Load into M, memory op (ValidE & (MemReadE|MemWriteE)), legal and aligned: state becomes ACCESS. DMemReq=1 from the next cycle, registered.
- Alignment rules:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=00.
  - Stores accept Funct3E 000/001/010 only.
  - Loads accept 000/001/010/100/101 only.
- Misaligned or illegal op: no request is issued. Next edge gives ValidW=1, FaultW=1, RegWriteW=0.
- Non-memory op: next edge gives ResultW=ALU result, RegWriteW as captured, ValidW=1.
- ACCESS: DMemReq=1 and all DMem outputs stable. In a cycle with DMemAck=1:
  - The W registers load on that edge and state returns to IDLE.
  - StallM = (state==ACCESS) & ~DMemAck.
  - DMemAck while DMemReq=0 is ignored.
- Store byte enables:
  - SB: BE = 4'b0001 << addr[1:0], data byte replicated ×4.
  - SH: BE = 4'b0011 << addr[1:0], data halfword replicated ×2.
  - SW: BE = 4'b1111.
- Stores complete with RegWriteW=0 and ValidW=1.
- Load extraction: shift DMemRData right by 8*addr[1:0], take the low byte or halfword, then sign-extend (B/H) or zero-extend (BU/HU). ResultW gets the extended value and RegWriteW=1.
- ValidW, FaultW and RegWriteW are single-cycle pulses per instruction; ResultW and RdW hold between updates.

## Timing
- Reset (nRESET=0 at an edge): state IDLE, M empty. DMemReq, DMemWe, DMemAddr, DMemBE, DMemWData, ResultW, RdW, RegWriteW, ValidW and FaultW are all 0. StallM is 0 from the cycle after reset.
- Reset during ACCESS abandons the request: DMemReq=0 after the reset edge and no W output is produced. The memory must tolerate a dropped request.
- Non-memory latency: E inputs at cycle n give W outputs after edge n+1.
- Zero-wait memory (ack in the first request cycle): the request is in cycle n+1 and W outputs follow edge n+2. There is no stall, so back-to-back loads sustain one per cycle.
- k wait cycles: StallM is high for k cycles and E inputs must stay stable throughout.
- Ack and a new E instruction in the same cycle: both the M slot and the W registers update on that edge, with no bubble.
- Funct3E and address checks use the registered M copy only.

## Test plan
- ALU op, ALUResultE=0x0000_1234, RdE=5, RegWriteE=1 -> one cycle later ValidW=1, ResultW=0x0000_1234, RdW=5, DMemReq stays 0.
- LB at addr 0x103, DMemRData=0x80FF_0000, ack immediate -> ResultW=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080. DMemAddr=0x100 in both cases.
- SH at addr 0x202, WriteDataE=0xAAAA_BEEF -> DMemBE=1100, DMemWData=0xBEEF_BEEF, DMemWe=1, RegWriteW=0.
- LW with DMemAck delayed 3 cycles -> StallM=1 for exactly 3 cycles, DMemReq and DMemAddr stable throughout, then ResultW=DMemRData.
- LW at addr 0x101 -> DMemReq never asserted, FaultW=1, RegWriteW=0, no stall.
- nRESET low during ACCESS -> DMemReq=0 next cycle and all outputs 0. A fresh load after reset completes normally.
